phase_fifo_ctrl: RTL and testbench
==================================

Name: phase_fifo_ctrl

Overview:
Sequencing controller for the 4-entry phase sample FIFO that sits between the demod phase output (symbol-rate write strobe) and the trellis decoder (symbol-rate read strobe).
- Flushes the FIFO, waits for a prefill level, then gates reads.
- Tracks fill level and detects overflow/underflow slips.
- Resynchronizes automatically after a slip and counts slip events for status registers.
- Drives the FIFO's reset, write-enable and read-enable inputs. Nothing else writes them.

Parameters:
DEPTH, 4, FIFO capacity in entries; must match the FIFO instance.
FILL_LEVEL, 2, entries required before reads are passed (range 1..DEPTH-1).
HOLDOFF, 8, cycles fifoReset is held in FLUSH (range 1..255).
CNT_W, 8, width of the slip counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  channel enable; low forces IDLE
wrReq  in  1  producer phase-sample strobe
rdReq  in  1  trellis read strobe
clrSlip  in  1  synchronous clear of slipCount
fifoReset  out  1  reset to phase FIFO
fifoWrEn  out  1  gated write enable to FIFO
fifoRdEn  out  1  gated read enable to FIFO
level  out  3  controller's tracked FIFO occupancy, 0..DEPTH
running  out  1  high in RUN state
overflow  out  1  one-cycle pulse on overflow slip
underflow  out  1  one-cycle pulse on underflow slip
slipCount  out  CNT_W  saturating count of slips

Behaviour:
States: IDLE, FLUSH, FILL, RUN. All state, level, counters and pulse outputs are registered.

Reset values:
- state=IDLE, level=0, slipCount=0.
- overflow=0, underflow=0, running=0.
- fifoReset=1, hold counter=0.

fifoReset:
- Registered.
- Equal to 1 while the next state is IDLE or FLUSH, else 0.

fifoWrEn and fifoRdEn:
- Combinational from wrReq/rdReq, current state and level. Zero latency.
- fifoWrEn = wrReq and state in {FILL, RUN} and (level<DEPTH, or (state==RUN and fifoRdEn)).
- fifoRdEn = rdReq and state==RUN and level>0.
- A write is never issued when level==DEPTH without a simultaneous read. This prevents the FIFO's internal full self-clear.

level:
- +1 on fifoWrEn only.
- -1 on fifoRdEn only.
- Unchanged when both or neither are active.
- Forced to 0 in IDLE and FLUSH.

State transitions:
- enable low in any state → IDLE on the next cycle. Highest priority after reset.
- IDLE: when enable=1 → FLUSH, with the hold counter loaded to HOLDOFF-1.
- FLUSH: the hold counter decrements each cycle. At 0 → FILL. The duration is exactly HOLDOFF cycles with fifoReset=1.
- FILL:
  - Writes are accepted. rdReq is ignored, with no underflow.
  - When level+fifoWrEn == FILL_LEVEL → RUN on the next cycle.
  - wrReq at level==DEPTH cannot occur because FILL_LEVEL<DEPTH.
- RUN:
  - Overflow event: wrReq=1, level==DEPTH, and no fifoRdEn.
  - Underflow event: rdReq=1 and level==0. A same-cycle write does not rescue it, because FIFO data is not readable in the cycle it is written.
  - On either event: the write/read is blocked, the corresponding pulse is asserted the next cycle, the state goes to FLUSH (hold counter reloaded), and slipCount increments.
  - If both events occur in the same cycle, both pulses are asserted and slipCount increments by 1.

slipCount:
- Saturates at all-ones.
- clrSlip has priority over a simultaneous increment; the result is 0.
- Unaffected by enable and state. Cleared only by reset or clrSlip.

running = (state==RUN), registered.

Reset asserted mid-operation returns everything to the reset values on the next edge. The FIFO is reset via fifoReset=1.

Test Plan:
1. Reset, enable=1, no strobes → fifoReset high for exactly 8 cycles after IDLE→FLUSH, then low. State is FILL, level=0, running=0.
2. In FILL, 2 wrReq pulses (rdReq also pulsed) → fifoRdEn stays 0, no underflow, level=2, running=1 the cycle after the 2nd write. Reads are then passed.
3. RUN, level=4, wrReq with no rdReq → fifoWrEn=0, overflow pulse 1 cycle, slipCount=1, fifoReset high 8 cycles, then FILL.
4. RUN, level=4, wrReq and rdReq together → both enables high, level stays 4, no overflow.
5. RUN, level=0, rdReq and wrReq together → fifoRdEn=0, underflow pulse, slipCount increments, resync through FLUSH.
6. Force 255 slips then one more → slipCount holds 255. clrSlip together with a slip → slipCount=0. enable low mid-RUN → IDLE, level=0, fifoReset=1 the next cycle.

Source files
------------

// File: rtl/phase_fifo_ctrl.sv
// phase_fifo_ctrl: sequencing controller for the phase sample FIFO between the
// demodulator phase output and the trellis decoder. Flushes the FIFO, prefills
// it to a threshold, then passes reads. It also tracks occupancy, detects
// overflow/underflow slips, resynchronises after a slip and counts slips.
module phase_fifo_ctrl #(
  parameter int DEPTH      = 4,
  parameter int FILL_LEVEL = 2,
  parameter int HOLDOFF    = 8,
  parameter int CNT_W      = 8,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             wrReq,
  input  logic             rdReq,
  input  logic             clrSlip,
  output logic             fifoReset,
  output logic             fifoWrEn,
  output logic             fifoRdEn,
  output logic [LVL_W-1:0] level,
  output logic             running,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] slipCount
);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_FILL, ST_RUN} state_t;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_FILL = LVL_W'(FILL_LEVEL);
  localparam logic [7:0]       HOLD_LD  = 8'(HOLDOFF - 1);

  state_t           state_reg, state_next;
  logic [7:0]       hold_reg, hold_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [CNT_W-1:0] slip_cnt_reg;
  logic             fifo_rst_reg, running_reg, ovf_reg, unf_reg;
  logic             wr_en, rd_en, ovf_event, unf_event, slip_event;

  // State register and hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Zero-latency strobe gating and slip detection from current state and level.
  always_comb begin
    rd_en     = rdReq && (state_reg == ST_RUN) && (level_reg != '0);
    ovf_event = (state_reg == ST_RUN) && wrReq && (level_reg == LVL_FULL) && !rd_en;
    // A same-cycle write cannot rescue an empty read: the new word is not yet readable.
    unf_event = (state_reg == ST_RUN) && rdReq && (level_reg == '0);
    wr_en     = 1'b0;
    if (state_reg == ST_FILL)
      wr_en = wrReq && (level_reg < LVL_FULL);
    else if (state_reg == ST_RUN)
      // A write at full depth only goes through alongside a read, so the FIFO never self-clears.
      wr_en = wrReq && !ovf_event && !unf_event && ((level_reg < LVL_FULL) || rd_en);
    slip_event = ovf_event || unf_event;
  end

  // Next-state decode; enable low overrides every other transition.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    if (!enable) begin
      state_next = ST_IDLE;
      hold_next  = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_FLUSH;
          hold_next  = HOLD_LD;
        end
        ST_FLUSH: begin
          if (hold_reg == '0) state_next = ST_FILL;
          else                hold_next  = hold_reg - 8'd1;
        end
        ST_FILL: begin
          if (level_reg + LVL_W'(wr_en) == LVL_FILL) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (slip_event) begin
            state_next = ST_FLUSH;
            hold_next  = HOLD_LD;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Occupancy follows the gated strobes and is zero whenever the FIFO is held in reset.
  always_comb begin
    level_next = level_reg;
    if ((state_next == ST_IDLE) || (state_next == ST_FLUSH))
      level_next = '0;
    else if (wr_en && !rd_en)
      level_next = level_reg + LVL_W'(1);
    else if (rd_en && !wr_en)
      level_next = level_reg - LVL_W'(1);
  end

  // Registered status outputs, FIFO reset and saturating slip counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg    <= '0;
      fifo_rst_reg <= 1'b1;
      running_reg  <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
      slip_cnt_reg <= '0;
    end else begin
      level_reg    <= level_next;
      fifo_rst_reg <= (state_next == ST_IDLE) || (state_next == ST_FLUSH);
      running_reg  <= (state_next == ST_RUN);
      ovf_reg      <= ovf_event;
      unf_reg      <= unf_event;
      if (clrSlip)
        slip_cnt_reg <= '0;
      else if (slip_event && (slip_cnt_reg != '1))
        slip_cnt_reg <= slip_cnt_reg + CNT_W'(1);
    end
  end

  assign fifoWrEn  = wr_en;
  assign fifoRdEn  = rd_en;
  assign fifoReset = fifo_rst_reg;
  assign level     = level_reg;
  assign running   = running_reg;
  assign overflow  = ovf_reg;
  assign underflow = unf_reg;
  assign slipCount = slip_cnt_reg;

endmodule

// File: tb/tb_phase_fifo_ctrl.sv
// Testbench for phase_fifo_ctrl: directed scenarios plus a randomized run
// checked against a queue-based behavioural model of the controller.
module tb_phase_fifo_ctrl;
  localparam int DEPTH = 4, FILL_LEVEL = 2, HOLDOFF = 8;
  localparam int M_IDLE = 0, M_FLUSH = 1, M_FILL = 2, M_RUN = 3;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, wrReq = 1'b0, rdReq = 1'b0, clrSlip = 1'b0;
  logic fifoReset, fifoWrEn, fifoRdEn, running, overflow, underflow;
  logic [2:0] level;
  logic [7:0] slipCount;

  int n_checks = 0, n_pass = 0;
  logic obs_wr, obs_rd;

  // Behavioural model: phase, flush cycles remaining, FIFO contents as a queue.
  int m_mode = M_IDLE, m_left = 0, m_slips = 0, m_id = 0;
  int m_q[$];
  bit m_ovf = 0, m_unf = 0, e_wr, e_rd, e_ovf, e_unf;

  phase_fifo_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .wrReq(wrReq), .rdReq(rdReq),
    .clrSlip(clrSlip), .fifoReset(fifoReset), .fifoWrEn(fifoWrEn),
    .fifoRdEn(fifoRdEn), .level(level), .running(running), .overflow(overflow),
    .underflow(underflow), .slipCount(slipCount)
  );

  always #5 clk = ~clk;

  task automatic model_comb(input bit wr, input bit rd);
    int occ;
    occ   = m_q.size();
    e_rd  = rd && m_mode == M_RUN && occ > 0;
    e_ovf = m_mode == M_RUN && wr && occ == DEPTH && !e_rd;
    e_unf = m_mode == M_RUN && rd && occ == 0;
    e_wr  = wr && ((m_mode == M_FILL && occ < DEPTH) ||
                   (m_mode == M_RUN && !e_ovf && !e_unf && (occ < DEPTH || e_rd)));
  endtask

  task automatic model_seq(input bit rst, input bit en, input bit clr);
    if (rst) begin
      m_mode = M_IDLE; m_q.delete(); m_slips = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    if (e_rd) void'(m_q.pop_front());
    if (e_wr) begin m_q.push_back(m_id); m_id++; end
    if (clr) m_slips = 0;
    else if ((e_ovf || e_unf) && m_slips < 255) m_slips++;
    m_ovf = e_ovf;
    m_unf = e_unf;
    if (!en) begin
      m_mode = M_IDLE; m_q.delete();
    end else begin
      case (m_mode)
        M_IDLE:  begin m_mode = M_FLUSH; m_left = HOLDOFF; end
        M_FLUSH: begin m_left--; if (m_left == 0) m_mode = M_FILL; end
        M_FILL:  if (m_q.size() == FILL_LEVEL) m_mode = M_RUN;
        default: if (e_ovf || e_unf) begin m_mode = M_FLUSH; m_left = HOLDOFF; m_q.delete(); end
      endcase
    end
  endtask

  // One clock: drive at negedge, sample gated strobes, advance, update model.
  task automatic cycle(input bit rst, input bit en, input bit wr, input bit rd, input bit clr);
    @(negedge clk);
    reset = rst; enable = en; wrReq = wr; rdReq = rd; clrSlip = clr;
    #1;
    obs_wr = fifoWrEn;
    obs_rd = fifoRdEn;
    model_comb(wr, rd);
    @(posedge clk);
    model_seq(rst, en, clr);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    n_checks++; if ({level, running, fifoReset} !== {3'd0, 1'b0, 1'b1})
      $display("FAIL reset_lvl_run_rst got=%b exp=%b", {level, running, fifoReset}, 5'b00001);
    else n_pass++;
    n_checks++; if ({overflow, underflow, slipCount} !== 10'd0)
      $display("FAIL reset_pulses_slip got=%b exp=0", {overflow, underflow, slipCount});
    else n_pass++;
    $display("test_reset: level=%0d fifoReset=%0d slipCount=%0d", level, fifoReset, slipCount);
  endtask

  task automatic test_flush_fill();
    int hi;
    hi = 0;
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (fifoReset !== 1'b1) break;
      hi++;
      cycle(0, 1, 0, 0, 0);
    end
    n_checks++; if (hi != HOLDOFF) $display("FAIL flush_len got=%0d exp=%0d", hi, HOLDOFF);
    else n_pass++;
    n_checks++; if ({level, running} !== 4'd0)
      $display("FAIL fill_entry got level=%0d running=%0d exp 0/0", level, running);
    else n_pass++;
    $display("test_flush_fill: fifoReset high %0d cycles", hi);
  endtask

  task automatic test_fill_gate();
    cycle(0, 1, 1, 1, 0);
    n_checks++; if ({obs_wr, obs_rd} !== 2'b10)
      $display("FAIL fill_gate1 got wr/rd=%b exp=10", {obs_wr, obs_rd});
    else n_pass++;
    n_checks++; if ({level, running, underflow} !== {3'd1, 1'b0, 1'b0})
      $display("FAIL fill_lvl1 got=%b exp=%b", {level, running, underflow}, 5'b00100);
    else n_pass++;
    cycle(0, 1, 1, 1, 0);
    n_checks++; if ({obs_rd, level, running, underflow} !== {1'b0, 3'd2, 1'b1, 1'b0})
      $display("FAIL fill_lvl2 got=%b exp=%b", {obs_rd, level, running, underflow}, 6'b001010);
    else n_pass++;
    cycle(0, 1, 0, 1, 0);
    n_checks++; if ({obs_rd, level} !== {1'b1, 3'd1})
      $display("FAIL run_read got rd=%0d level=%0d exp 1/1", obs_rd, level);
    else n_pass++;
    $display("test_fill_gate: running=%0d level=%0d", running, level);
  endtask

  task automatic test_overflow();
    int hi;
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    n_checks++; if (level !== 3'd4) $display("FAIL run_full got=%0d exp=4", level);
    else n_pass++;
    cycle(0, 1, 1, 1, 0);
    n_checks++; if ({obs_wr, obs_rd, level, overflow} !== {1'b1, 1'b1, 3'd4, 1'b0})
      $display("FAIL full_rw got=%b exp=%b", {obs_wr, obs_rd, level, overflow}, 6'b111000);
    else n_pass++;
    cycle(0, 1, 1, 0, 0);
    n_checks++; if ({obs_wr, overflow, fifoReset, slipCount} !== {1'b0, 1'b1, 1'b1, 8'd1})
      $display("FAIL ovf_event got=%b exp=%b", {obs_wr, overflow, fifoReset, slipCount}, {3'b011, 8'd1});
    else n_pass++;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (fifoReset !== 1'b1) break;
      hi++;
      cycle(0, 1, 0, 0, 0);
      if (i == 0) begin
        n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_pulse_len got=%0d exp=0", overflow);
        else n_pass++;
      end
    end
    n_checks++; if (hi != HOLDOFF || running !== 1'b0 || level !== 3'd0)
      $display("FAIL ovf_resync got hold=%0d running=%0d level=%0d exp 8/0/0", hi, running, level);
    else n_pass++;
    $display("test_overflow: slipCount=%0d resync hold=%0d", slipCount, hi);
  endtask

  task automatic test_underflow();
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 1, 0);
    n_checks++; if ({running, level} !== {1'b1, 3'd0})
      $display("FAIL run_empty got running=%0d level=%0d exp 1/0", running, level);
    else n_pass++;
    cycle(0, 1, 1, 1, 0);
    n_checks++; if ({obs_wr, obs_rd, underflow, overflow, fifoReset, slipCount} !== {5'b00101, 8'd2})
      $display("FAIL unf_event got=%b exp=%b", {obs_wr, obs_rd, underflow, overflow, fifoReset, slipCount}, {5'b00101, 8'd2});
    else n_pass++;
    $display("test_underflow: slipCount=%0d", slipCount);
  endtask

  task automatic test_saturation();
    bit ok;
    for (int i = 0; i < 8000 && m_slips < 255; i++)
      cycle(0, 1, m_mode != M_RUN, m_mode == M_RUN, 0);
    n_checks++; if (slipCount !== 8'd255) $display("FAIL slip_reach_max got=%0d exp=255", slipCount);
    else n_pass++;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cycle(0, 1, m_mode != M_RUN, m_mode == M_RUN, 0);
      ok = m_unf;
    end
    n_checks++; if (!ok || underflow !== 1'b1 || slipCount !== 8'd255)
      $display("FAIL slip_saturate got unf=%0d slip=%0d exp 1/255", underflow, slipCount);
    else n_pass++;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (m_mode == M_RUN && m_q.size() == 0) ok = 1;
      else cycle(0, 1, m_mode != M_RUN, m_mode == M_RUN, 0);
    end
    cycle(0, 1, 0, 1, 1);
    n_checks++; if (!ok || underflow !== 1'b1 || slipCount !== 8'd0)
      $display("FAIL clr_vs_slip got unf=%0d slip=%0d exp 1/0", underflow, slipCount);
    else n_pass++;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      cycle(0, 1, 1, 0, 0);
      ok = (m_mode == M_RUN);
    end
    cycle(0, 0, 1, 0, 0);
    n_checks++; if (!ok || {level, fifoReset, running} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL enable_low got level=%0d fifoReset=%0d running=%0d exp 0/1/0", level, fifoReset, running);
    else n_pass++;
    $display("test_saturation: slipCount=%0d after clear, idle level=%0d", slipCount, level);
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 97, 1'($urandom),
            1'($urandom), $urandom_range(0, 49) == 0);
      n_checks++; if ({obs_wr, obs_rd} !== {e_wr, e_rd}) begin
        errs++; $display("FAIL rnd_strobes cyc=%0d got=%b exp=%b", i, {obs_wr, obs_rd}, {e_wr, e_rd});
      end else n_pass++;
      n_checks++; if (level !== 3'(m_q.size())) begin
        errs++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, m_q.size());
      end else n_pass++;
      n_checks++; if ({fifoReset, running} !== {m_mode <= M_FLUSH, m_mode == M_RUN}) begin
        errs++; $display("FAIL rnd_state cyc=%0d got rst/run=%b mode=%0d", i, {fifoReset, running}, m_mode);
      end else n_pass++;
      n_checks++; if ({overflow, underflow, slipCount} !== {m_ovf, m_unf, 8'(m_slips)}) begin
        errs++; $display("FAIL rnd_slip cyc=%0d got=%b exp=%b", i, {overflow, underflow, slipCount}, {m_ovf, m_unf, 8'(m_slips)});
      end else n_pass++;
      if (m_ovf || m_unf)
        $display("slip cyc=%0d ovf=%0d unf=%0d slipCount=%0d", i, overflow, underflow, slipCount);
    end
    $display("test_random: 800 cycles, %0d mismatched checks", errs);
  endtask

  initial begin
    test_reset();
    test_flush_fill();
    test_fill_gate();
    test_overflow();
    test_underflow();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
